// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment frame sequencer.
package sevseg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DWELL,
      ADVANCE
   } state_e;

   localparam int               N_FRAMES  = 4;
   localparam int               SEG_W     = 7;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/sevseg_next_frame.sv
// Masked rotate search: first enabled frame after the current one, walking in
// the selected direction modulo N_FRAMES; reports change and wrap-around.
module sevseg_next_frame
   import sevseg_pkg::*;
(
   input  logic [1:0]          cur_sel_i,
   input  logic [N_FRAMES-1:0] mask_i,
   input  logic                dir_i,
   output logic [1:0]          next_sel_o,
   output logic                changed_o,
   output logic                wrapped_o
);

   logic [1:0] cand;
   logic       found;

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      next_sel_o = cur_sel_i;
      cand       = '0;
      found      = 1'b0;
      for (int k = 1; k <= N_FRAMES; k++) begin
         cand = dir_i ? cur_sel_i - 2'(k) : cur_sel_i + 2'(k);
         if (!found && mask_i[cand]) begin
            next_sel_o = cand;
            found      = 1'b1;
         end
      end
   end

   assign changed_o = (next_sel_o != cur_sel_i);
   assign wrapped_o = changed_o && (dir_i ? (next_sel_o > cur_sel_i)
                                          : (next_sel_o < cur_sel_i));

endmodule

// File: rtl/sevseg_seq.sv
// Frame sequencer: FSM, dwell counter and registered segment/strobe outputs.
// Optional blink of the second half of each dwell when SEVSEG_BLINK_EN is defined.
module sevseg_seq
   import sevseg_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_run,
   input  logic             i_step,
   input  logic             i_dir,
   input  logic [3:0]       i_mask,
   input  logic [CNT_W-1:0] i_dwell,
   input  logic             i_blink,
   input  logic [6:0]       i_seg,
   output logic [1:0]       o_sel,
   output logic [6:0]       o_seg,
   output logic             o_frame_stb,
   output logic             o_wrap
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       sel_q;
   logic [6:0]       seg_q;
   logic [6:0]       seg_d;
   logic             stb_q;
   logic             wrap_q;
   logic [1:0]       nxt_sel;
   logic             nxt_changed;
   logic             nxt_wrapped;
   logic             blink_blank;

   sevseg_next_frame u_next_frame (
      .cur_sel_i  (sel_q),
      .mask_i     (i_mask),
      .dir_i      (i_dir),
      .next_sel_o (nxt_sel),
      .changed_o  (nxt_changed),
      .wrapped_o  (nxt_wrapped)
   );

`ifdef SEVSEG_BLINK_EN
   logic [CNT_W:0] half_dwell;
   assign half_dwell  = ({1'b0, i_dwell} + (CNT_W+1)'(1)) >> 1;
   assign blink_blank = i_blink && (state_q == DWELL) && ({1'b0, cnt_q} < half_dwell);
`else
   logic unused_blink;
   assign unused_blink = i_blink;
   assign blink_blank  = 1'b0;
`endif

   always_comb begin
      seg_d = i_seg;
      if ((i_mask == 4'b0000) || blink_blank)
         seg_d = SEG_BLANK;
   end

   // NOTE: all state here is sequential, so only non-blocking assignments are used.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         seg_q   <= SEG_BLANK;
         stb_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         seg_q  <= seg_d;
         stb_q  <= 1'b0;
         wrap_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_run) begin
                  state_q <= DWELL;
                  cnt_q   <= i_dwell;
               end else if (i_step) begin
                  state_q <= ADVANCE;
               end
            end
            DWELL: begin
               // Dropping run aborts the dwell even when the count has expired.
               if (!i_run)
                  state_q <= IDLE;
               else if (cnt_q == '0)
                  state_q <= ADVANCE;
               else
                  cnt_q <= cnt_q - CNT_W'(1);
            end
            ADVANCE: begin
               sel_q   <= nxt_sel;
               stb_q   <= nxt_changed;
               wrap_q  <= nxt_wrapped;
               cnt_q   <= i_dwell;
               state_q <= i_run ? DWELL : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_sel       = sel_q;
   assign o_seg       = seg_q;
   assign o_frame_stb = stb_q;
   assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_sevseg_seq.sv
// Self-checking bench for sevseg_seq: directed scenarios plus random stimulus,
// compared every cycle against a deadline-based reference model.
module tb_sevseg_seq;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_run;
   logic        i_step;
   logic        i_dir;
   logic [3:0]  i_mask;
   logic [15:0] i_dwell;
   logic        i_blink;
   logic [6:0]  i_seg;
   logic [1:0]  o_sel;
   logic [6:0]  o_seg;
   logic        o_frame_stb;
   logic        o_wrap;

   logic [6:0]  pat [4];

   int errors = 0;
   int checks = 0;

   // Reference model: selected frame, busy flag and the absolute edge index of
   // the next frame update (the ADVANCE edge).
   int          m_sel;
   bit          m_busy;
   int          m_due;
   int          m_t;
   logic [6:0]  e_seg;
   bit          e_stb;
   bit          e_wrap;

   sevseg_seq #(.CNT_W(16)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_run       (i_run),
      .i_step      (i_step),
      .i_dir       (i_dir),
      .i_mask      (i_mask),
      .i_dwell     (i_dwell),
      .i_blink     (i_blink),
      .i_seg       (i_seg),
      .o_sel       (o_sel),
      .o_seg       (o_seg),
      .o_frame_stb (o_frame_stb),
      .o_wrap      (o_wrap)
   );

   always #5 i_clk = ~i_clk;

   assign i_seg = pat[o_sel];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int next_frame_ref(int cur, logic [3:0] mask, bit dir);
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = dir ? (cur - k + 4) % 4 : (cur + k) % 4;
         if (mask[idx]) return idx;
      end
      return cur;
   endfunction

   task automatic model_reset();
      m_sel  = 0;
      m_busy = 0;
      m_due  = 0;
      e_seg  = 7'h00;
      e_stb  = 0;
      e_wrap = 0;
   endtask

   // Predicts outputs after the upcoming edge from the inputs currently applied.
   task automatic model_edge();
      int  t;
      int  d;
      int  nxt;
      bit  blank;
      t     = m_t;
      d     = int'(i_dwell);
      blank = (i_mask == 4'b0000);
`ifdef SEVSEG_BLINK_EN
      if (i_blink && m_busy && (t < m_due) && ((m_due - t - 1) < ((d + 1) / 2)))
         blank = 1;
`endif
      e_seg  = blank ? 7'h00 : pat[m_sel];
      e_stb  = 0;
      e_wrap = 0;
      if (!m_busy) begin
         if (i_run) begin
            m_busy = 1;
            m_due  = t + d + 2;
         end else if (i_step) begin
            m_busy = 1;
            m_due  = t + 1;
         end
      end else if (t < m_due) begin
         if (!i_run) m_busy = 0;
      end else begin
         nxt = next_frame_ref(m_sel, i_mask, i_dir);
         if (nxt != m_sel) begin
            e_stb  = 1;
            e_wrap = i_dir ? (nxt > m_sel) : (nxt < m_sel);
         end
         m_sel = nxt;
         if (i_run) m_due = t + d + 2;
         else       m_busy = 0;
      end
      m_t++;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge i_clk);
      #1;
      check("sel", 32'(o_sel), 32'(m_sel));
      check("seg", 32'(o_seg), 32'(e_seg));
      check("frame_stb", 32'(o_frame_stb), 32'(e_stb));
      check("wrap", 32'(o_wrap), 32'(e_wrap));
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) pat[i] = 7'($urandom_range(1, 127));
      i_rst   = 1'b1;
      i_run   = 1'b0;
      i_step  = 1'b0;
      i_dir   = 1'b0;
      i_mask  = 4'b1111;
      i_dwell = 16'd0;
      i_blink = 1'b0;
      model_reset();
      m_t = 0;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_sel", 32'(o_sel), 32'd0);
      check("reset_seg", 32'(o_seg), 32'd0);
      check("reset_stb", 32'(o_frame_stb), 32'd0);
      check("reset_wrap", 32'(o_wrap), 32'd0);
      i_rst = 1'b0;
      run_cycles(3);

      // Ascending over all four frames, period 5.
      i_run = 1'b1; i_dwell = 16'd3; i_mask = 4'b1111; i_dir = 1'b0;
      run_cycles(22);

      // Descending over frames 0 and 2 with zero dwell.
      i_mask = 4'b0101; i_dir = 1'b1; i_dwell = 16'd0;
      run_cycles(12);

      // No frame enabled, then only frame 1.
      i_mask = 4'b0000;
      run_cycles(12);
      i_mask = 4'b0010;
      run_cycles(12);

      // Single step from frame 1 while stopped.
      i_run = 1'b0; i_mask = 4'b1111; i_dir = 1'b0;
      run_cycles(2);
      check("pre_step_sel", 32'(o_sel), 32'd1);
      i_step = 1'b1;
      cycle();
      i_step = 1'b0;
      cycle();
      check("step_sel", 32'(o_sel), 32'd2);
      run_cycles(6);

      // Blink enable: honoured only in builds with the blink feature.
      for (int i = 0; i < 4; i++) pat[i] = 7'h3F;
      i_blink = 1'b1; i_dwell = 16'd7; i_run = 1'b1;
      run_cycles(40);
      i_run = 1'b0; i_blink = 1'b0;
      run_cycles(2);

      // Random stimulus.
      for (int i = 0; i < 4; i++) pat[i] = 7'($urandom_range(1, 127));
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) i_run   = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 7) == 0) i_mask  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) i_dir   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) i_dwell = 16'($urandom_range(0, 4));
         if ($urandom_range(0, 15) == 0) i_blink = 1'($urandom_range(0, 1));
         i_step = ($urandom_range(0, 5) == 0);
         cycle();
      end
      i_step = 1'b0;

      // Asynchronous reset while dwelling on frame 2.
      i_run = 1'b0; i_blink = 1'b0;
      run_cycles(2);
      i_mask = 4'b1111; i_dir = 1'b0; i_dwell = 16'd5; i_run = 1'b1;
      for (int i = 0; i < 60 && m_sel != 2; i++) cycle();
      cycle();
      check("reach_sel2", 32'(o_sel), 32'd2);
      #2;
      i_rst = 1'b1;
      #1;
      check("async_rst_sel", 32'(o_sel), 32'd0);
      check("async_rst_seg", 32'(o_seg), 32'd0);
      check("async_rst_stb", 32'(o_frame_stb), 32'd0);
      check("async_rst_wrap", 32'(o_wrap), 32'd0);
      model_reset();
      @(posedge i_clk);
      m_t++;
      #2;
      i_rst = 1'b0;
      i_run = 1'b0;
      run_cycles(6);
      check("idle_after_rst", 32'(o_sel), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
